// File: rtl/nc_bram_model.sv
// Parametrised single-clock block RAM: read/write port A, read-only monitor port B,
// configurable read latency (1 or 2), write-collision mode and a sticky out-of-range flag.
module nc_bram_model #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 16,
  parameter int                DEPTH      = 65536,
  parameter int                RD_LAT     = 1,
  parameter int                WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] RST_VAL    = '0
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  ena,
  input  logic [DATA_W/8-1:0]   wea,
  input  logic [ADDR_W-1:0]     addra,
  input  logic [DATA_W-1:0]     dina,
  output logic [DATA_W-1:0]     douta,
  input  logic                  enb,
  input  logic [ADDR_W-1:0]     addrb,
  output logic [DATA_W-1:0]     doutb,
  output logic                  oob_err
);

  localparam int              NB      = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              a_acc, a_in, a_wr, a_load;
  logic [IDX_W-1:0]  a_idx;
  logic [DATA_W-1:0] a_old, a_merged, a_rd;
  logic              b_acc, b_in;
  logic [IDX_W-1:0]  b_idx;
  logic [DATA_W-1:0] b_rd;
  logic [DATA_W-1:0] douta_q, douta_d, doutb_q, doutb_d;
  logic              oob_q, oob_d;

  // Accesses presented while rsta is high are ignored entirely.
  always_comb begin
    a_acc    = ena & ~rsta;
    a_in     = {1'b0, addra} < DEPTH_L;
    a_idx    = addra[IDX_W-1:0];
    a_old    = a_in ? mem_q[a_idx] : '0;
    a_merged = a_old;
    for (int i = 0; i < NB; i++) begin
      if (wea[i]) a_merged[8*i +: 8] = dina[8*i +: 8];
    end
    a_wr   = a_acc & a_in & (|wea);
    a_load = a_acc & ~((WRITE_MODE == 2) & a_wr);
    if (!a_in)                 a_rd = '0;
    else if (WRITE_MODE == 1)  a_rd = a_merged;
    else                       a_rd = a_old;
  end

  always_comb begin
    b_acc = enb & ~rsta;
    b_in  = {1'b0, addrb} < DEPTH_L;
    b_idx = addrb[IDX_W-1:0];
    b_rd  = b_in ? mem_q[b_idx] : '0;
    oob_d = oob_q | (a_acc & ~a_in) | (b_acc & ~b_in);
  end

  always_ff @(posedge clka) begin
    if (a_wr) mem_q[a_idx] <= a_merged;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] a_s1_q, a_s1_d, b_s1_q, b_s1_d;
      logic              a_vld_q, a_vld_d, b_vld_q, b_vld_d;

      // Stage 2 only loads when the previous edge carried an enabled read.
      always_comb begin
        a_s1_d  = a_load ? a_rd : a_s1_q;
        b_s1_d  = b_acc ? b_rd : b_s1_q;
        a_vld_d = a_load;
        b_vld_d = b_acc;
        douta_d = a_vld_q ? a_s1_q : douta_q;
        doutb_d = b_vld_q ? b_s1_q : doutb_q;
      end

      always_ff @(posedge clka) begin
        a_s1_q <= a_s1_d;
        b_s1_q <= b_s1_d;
        if (rsta) begin
          a_vld_q <= 1'b0;
          b_vld_q <= 1'b0;
        end else begin
          a_vld_q <= a_vld_d;
          b_vld_q <= b_vld_d;
        end
      end
    end else begin : g_lat1
      always_comb begin
        douta_d = a_load ? a_rd : douta_q;
        doutb_d = b_acc ? b_rd : doutb_q;
      end
    end
  endgenerate

  always_ff @(posedge clka) begin
    if (rsta) begin
      douta_q <= RST_VAL;
      doutb_q <= RST_VAL;
      oob_q   <= 1'b0;
    end else begin
      douta_q <= douta_d;
      doutb_q <= doutb_d;
      oob_q   <= oob_d;
    end
  end

  assign douta   = douta_q;
  assign doutb   = doutb_q;
  assign oob_err = oob_q;

endmodule

// File: tb/tb_nc_bram_model.sv
// Bench for nc_bram_model: three RD_LAT=1 instances (one per write mode) and one RD_LAT=2
// instance share the same stimulus; a vector table plus latency/reset sequences check them.
module tb_nc_bram_model;

  localparam logic [31:0] RV1 = 32'hCAFE_F00D;
  localparam logic [31:0] RV2 = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst, ena, enb;
  logic [3:0]  wea;
  logic [15:0] addra, addrb;
  logic [31:0] dina;
  logic [31:0] douta0, douta1, douta2, douta3;
  logic [31:0] doutb0, doutb1, doutb2, doutb3;
  logic        oob0, oob1, oob2, oob3;

  always #5 clk = ~clk;

  nc_bram_model #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .RD_LAT(1), .WRITE_MODE(0), .RST_VAL(RV1)) u0 (
    .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0),
    .enb(enb), .addrb(addrb), .doutb(doutb0), .oob_err(oob0));
  nc_bram_model #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .RD_LAT(1), .WRITE_MODE(1), .RST_VAL(RV1)) u1 (
    .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1),
    .enb(enb), .addrb(addrb), .doutb(doutb1), .oob_err(oob1));
  nc_bram_model #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .RD_LAT(1), .WRITE_MODE(2), .RST_VAL(RV1)) u2 (
    .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta2),
    .enb(enb), .addrb(addrb), .doutb(doutb2), .oob_err(oob2));
  nc_bram_model #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .RD_LAT(2), .WRITE_MODE(0), .RST_VAL(RV2)) u3 (
    .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta3),
    .enb(enb), .addrb(addrb), .doutb(doutb3), .oob_err(oob3));

  typedef struct {
    string       name;
    logic        rst;
    logic        ena;
    logic [3:0]  wea;
    logic [15:0] addra;
    logic [31:0] dina;
    logic        enb;
    logic [15:0] addrb;
    logic [31:0] exp_a0, exp_a1, exp_a2, exp_b;
    logic [2:0]  chk_a;
    logic        exp_oob;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int          s_addr[8] = '{9, 3, 5, 1023, 0, 1, 2, 7};
  logic [31:0] s_val[8]  = '{32'h99, 32'h0, 32'h0, 32'h3FF0_3FF0, 32'd10, 32'd11, 32'd12, 32'h1234};

  function automatic vec_t mk(input string name, input logic r, input logic ea, input logic [3:0] we,
                              input logic [15:0] aa, input logic [31:0] da, input logic eb,
                              input logic [15:0] ab, input logic [31:0] ea0, input logic [31:0] ea1,
                              input logic [31:0] ea2, input logic [31:0] eb_v, input logic [2:0] mask,
                              input logic eo);
    vec_t v;
    v.name = name; v.rst = r; v.ena = ea; v.wea = we; v.addra = aa; v.dina = da;
    v.enb = eb; v.addrb = ab; v.exp_a0 = ea0; v.exp_a1 = ea1; v.exp_a2 = ea2;
    v.exp_b = eb_v; v.chk_a = mask; v.exp_oob = eo;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; ena = v.ena; wea = v.wea; addra = v.addra; dina = v.dina;
    enb = v.enb; addrb = v.addrb;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    vec_t v;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
      return;
    end
    v = exp_q.pop_front();
    if (v.chk_a[0]) checkVal({v.name, " douta m0"}, douta0, v.exp_a0);
    if (v.chk_a[1]) checkVal({v.name, " douta m1"}, douta1, v.exp_a1);
    if (v.chk_a[2]) checkVal({v.name, " douta m2"}, douta2, v.exp_a2);
    checkVal({v.name, " doutb m0"}, doutb0, v.exp_b);
    checkVal({v.name, " doutb m1"}, doutb1, v.exp_b);
    checkVal({v.name, " doutb m2"}, doutb2, v.exp_b);
    checkVal({v.name, " oob m0"}, {31'b0, oob0}, {31'b0, v.exp_oob});
    checkVal({v.name, " oob m1"}, {31'b0, oob1}, {31'b0, v.exp_oob});
    checkVal({v.name, " oob m2"}, {31'b0, oob2}, {31'b0, v.exp_oob});
    checkVal({v.name, " oob lat2"}, {31'b0, oob3}, {31'b0, v.exp_oob});
  endtask

  task automatic cyc(input logic r, input logic ea, input logic [15:0] aa);
    rst = r; ena = ea; wea = 4'h0; addra = aa; dina = 32'h0; enb = 1'b0; addrb = 16'h0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; enb = 1'b0; wea = 4'h0; addra = '0; addrb = '0; dina = '0;

    vecs.push_back(mk("reset", 1, 0, 4'h0, 0, 0, 0, 0, RV1, RV1, RV1, RV1, 3'b111, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk($sformatf("setup%0d", i), 0, 1, 4'hF, 16'(s_addr[i]), s_val[i], 0, 0,
                        32'h0, s_val[i], RV1, RV1, 3'b110, 0));
    vecs.push_back(mk("rst_access", 1, 1, 4'hF, 9, 32'hFFFF_FFFF, 1, 1024, RV1, RV1, RV1, RV1, 3'b111, 0));
    vecs.push_back(mk("idle_hold", 0, 0, 4'h0, 0, 0, 0, 0, RV1, RV1, RV1, RV1, 3'b111, 0));
    vecs.push_back(mk("wr5_full", 0, 1, 4'hF, 5, 32'hAABB_CCDD, 0, 0,
                      32'h0, 32'hAABB_CCDD, RV1, RV1, 3'b111, 0));
    vecs.push_back(mk("wr5_lanes", 0, 1, 4'b0101, 5, 32'h1122_3344, 1, 5,
                      32'hAABB_CCDD, 32'hAA22_CC44, RV1, 32'hAABB_CCDD, 3'b111, 0));
    vecs.push_back(mk("rd5", 0, 1, 4'h0, 5, 0, 0, 0,
                      32'hAA22_CC44, 32'hAA22_CC44, 32'hAA22_CC44, 32'hAABB_CCDD, 3'b111, 0));
    vecs.push_back(mk("collide3", 0, 1, 4'hF, 3, 32'hDEAD_BEEF, 1, 3,
                      32'h0, 32'hDEAD_BEEF, 32'hAA22_CC44, 32'h0, 3'b111, 0));
    vecs.push_back(mk("rdb3_after_wr", 0, 0, 4'h0, 0, 0, 1, 3,
                      32'h0, 32'hDEAD_BEEF, 32'hAA22_CC44, 32'hDEAD_BEEF, 3'b111, 0));
    vecs.push_back(mk("rda3_rdb9", 0, 1, 4'h0, 3, 0, 1, 9,
                      32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h99, 3'b111, 0));
    vecs.push_back(mk("wea_no_ena", 0, 0, 4'hF, 3, 0, 1, 3,
                      32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b111, 0));
    vecs.push_back(mk("oob_wr", 0, 1, 4'hF, 1024, 32'h55, 0, 0,
                      32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 3'b011, 1));
    vecs.push_back(mk("oob_rd", 0, 1, 4'h0, 1024, 0, 0, 0,
                      32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 3'b111, 1));
    vecs.push_back(mk("rd1023", 0, 1, 4'h0, 1023, 0, 1, 1023,
                      32'h3FF0_3FF0, 32'h3FF0_3FF0, 32'h3FF0_3FF0, 32'h3FF0_3FF0, 3'b111, 1));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk($sformatf("oob_sticky%0d", i), 0, 0, 4'h0, 0, 0, 0, 0,
                        32'h3FF0_3FF0, 32'h3FF0_3FF0, 32'h3FF0_3FF0, 32'h3FF0_3FF0, 3'b111, 1));
    vecs.push_back(mk("oob_clear", 1, 0, 4'h0, 0, 0, 0, 0, RV1, RV1, RV1, RV1, 3'b111, 0));
    vecs.push_back(mk("post_reset", 0, 0, 4'h0, 0, 0, 0, 0, RV1, RV1, RV1, RV1, 3'b111, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // RD_LAT=2 back-to-back reads, then a one-cycle gap
    checkVal("lat2 reset value", douta3, RV2);
    cyc(0, 1, 0);  checkVal("lat2 rd0 not yet", douta3, RV2);
    cyc(0, 1, 1);  checkVal("lat2 data0", douta3, 32'd10);
    cyc(0, 1, 2);  checkVal("lat2 data1", douta3, 32'd11);
    cyc(0, 0, 0);  checkVal("lat2 data2", douta3, 32'd12);
    cyc(0, 0, 0);  checkVal("lat2 idle hold", douta3, 32'd12);
    cyc(0, 1, 0);  checkVal("lat2 gap rd0 pending", douta3, 32'd12);
    cyc(0, 0, 0);  checkVal("lat2 gap data0", douta3, 32'd10);
    cyc(0, 1, 1);  checkVal("lat2 gap extra hold", douta3, 32'd10);
    cyc(0, 1, 2);  checkVal("lat2 gap data1", douta3, 32'd11);
    cyc(0, 0, 0);  checkVal("lat2 gap data2", douta3, 32'd12);

    // RD_LAT=2 reset while a read is in flight
    cyc(0, 1, 7);  checkVal("rstmid issue", douta3, 32'd12);
    cyc(1, 1, 7);  checkVal("rstmid in reset", douta3, RV2);
    checkVal("rstmid oob", {31'b0, oob3}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      checkVal($sformatf("rstmid discard%0d", i), douta3, RV2);
    end
    cyc(0, 1, 7);  checkVal("rstmid reread pending", douta3, RV2);
    cyc(0, 0, 0);  checkVal("rstmid reread data", douta3, 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
